// File: rtl/rll27_pkg.sv
// Shared types and code table for the RLL(2,7) stream encoder.
// Code words are stored left-aligned in 8 bits; the length field says how many leading bits are real.
package rll27_pkg;

    localparam int MAX_CODE_LEN = 8;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_0    = 3'd1,
        P_1    = 3'd2,
        P_00   = 3'd3,
        P_01   = 3'd4,
        P_001  = 3'd5
    } parser_state_t;

    // Input word -> code word (left-aligned, MSB is the first code bit on the line)
    localparam logic [7:0] CODE_10   = 8'b0100_0000;
    localparam logic [7:0] CODE_11   = 8'b1000_0000;
    localparam logic [7:0] CODE_000  = 8'b0001_0000;
    localparam logic [7:0] CODE_010  = 8'b1001_0000;
    localparam logic [7:0] CODE_011  = 8'b0010_0000;
    localparam logic [7:0] CODE_0010 = 8'b0010_0100;
    localparam logic [7:0] CODE_0011 = 8'b0000_1000;

    localparam logic [3:0] LEN_SHORT = 4'd4;
    localparam logic [3:0] LEN_MID   = 4'd6;
    localparam logic [3:0] LEN_LONG  = 4'd8;

endpackage

// File: rtl/rll27_parser.sv
// Prefix parser for the RLL(2,7) code: walks the input-word tree and emits a code word
// combinationally on the bit that completes a word.
module rll27_parser
    import rll27_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_data,
    output logic       emit,
    output logic [7:0] code,
    output logic [3:0] code_len
);

    parser_state_t state;
    parser_state_t state_next;

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        code       = '0;
        code_len   = '0;
        if (bit_valid) begin
            unique case (state)
                P_IDLE: state_next = bit_data ? P_1 : P_0;
                P_0:    state_next = bit_data ? P_01 : P_00;
                P_1: begin
                    emit       = 1'b1;
                    state_next = P_IDLE;
                    code       = bit_data ? CODE_11 : CODE_10;
                    code_len   = LEN_SHORT;
                end
                P_00: begin
                    if (bit_data) begin
                        state_next = P_001;
                    end else begin
                        emit       = 1'b1;
                        state_next = P_IDLE;
                        code       = CODE_000;
                        code_len   = LEN_MID;
                    end
                end
                P_01: begin
                    emit       = 1'b1;
                    state_next = P_IDLE;
                    code       = bit_data ? CODE_011 : CODE_010;
                    code_len   = LEN_MID;
                end
                P_001: begin
                    emit       = 1'b1;
                    state_next = P_IDLE;
                    code       = bit_data ? CODE_0011 : CODE_0010;
                    code_len   = LEN_LONG;
                end
                default: state_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= P_IDLE;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/rll27_stream_encoder.sv
// RLL(2,7) stream encoder: serial NRZ in, OUT_W-bit code words out, valid/ready on both sides.
// Define RLL27_NRZI_EN to NRZI-map code bits before they are packed.
module rll27_stream_encoder
    import rll27_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int ACC_W = OUT_W + MAX_CODE_LEN;
    localparam int FW    = $clog2(ACC_W + 1);
    localparam logic [FW-1:0] OUT_W_F = FW'(OUT_W);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // data_o is held unchanged while valid_o is high and ready_i is low.

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_popped;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] code_ext;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_rem;
    logic [FW-1:0]    fill_next;
    logic             accept;
    logic             pop;
    logic             emit;
    logic [7:0]       code;
    logic [7:0]       line_code;
    logic [3:0]       code_len;

    // Accepting only while fill <= OUT_W leaves room for a full 8-bit emit.
    assign ready_o = (fill <= OUT_W_F);
    assign accept  = valid_i & ready_o;
    assign pop     = (fill >= OUT_W_F) && (!valid_o || ready_i);

    rll27_parser u_parser (
        .clk       (clk_i),
        .rst       (arst_i),
        .bit_valid (accept),
        .bit_data  (data_i),
        .emit      (emit),
        .code      (code),
        .code_len  (code_len)
    );

`ifdef RLL27_NRZI_EN
    logic level;
    logic level_next;

    always_comb begin
        level_next = level;
        line_code  = '0;
        for (int i = 0; i < MAX_CODE_LEN; i++) begin
            if (i < int'(code_len)) begin
                level_next       = level_next ^ code[7-i];
                line_code[7-i]   = level_next;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            level <= 1'b0;
        end else if (emit) begin
            level <= level_next;
        end
    end
`else
    assign line_code = code;
`endif

    // Accumulator is left-aligned: oldest bit at acc[ACC_W-1], bits below fill are kept zero.
    always_comb begin
        acc_popped = pop ? (acc << OUT_W) : acc;
        fill_rem   = pop ? (fill - OUT_W_F) : fill;
        code_ext   = {line_code, {OUT_W{1'b0}}};
        acc_next   = acc_popped;
        fill_next  = fill_rem;
        if (emit) begin
            acc_next  = acc_popped | (code_ext >> fill_rem);
            fill_next = fill_rem + FW'(code_len);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (pop) begin
            data_o  <= acc[ACC_W-1 -: OUT_W];
            valid_o <= 1'b1;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
